// File: rtl/down_count_monitor.sv
// down_count_monitor
// Watches the count bus of a down counter and checks that every step is
// a decrement by one (0 wraps to all-ones) or a hold. Counts legal wraps
// with a saturating counter, reports a stall after STALL_LIMIT consecutive
// holds, and latches a sticky error on any other transition.
// All outputs come straight from flops.

module down_count_monitor #(
    parameter int WIDTH       = 4,
    parameter int WRAP_W      = 8,
    parameter int STALL_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              enable,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              stall,
    output logic              err,
    output logic [1:0]        state
);

    // Width of the held-sample counter; it must be able to hold STALL_LIMIT.
    localparam int SCNT_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_STALL = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    // Value a legal decrement from prev must present (all-ones after 0).
    function automatic logic [WIDTH-1:0] expected_next(input logic [WIDTH-1:0] prev_v);
        return prev_v - {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // True when prev is zero, i.e. the next legal decrement is a wrap.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Saturating increment of the wrap counter.
    function automatic logic [WRAP_W-1:0] wrap_inc(input logic [WRAP_W-1:0] v);
        logic [WRAP_W-1:0] r;
        if (v == {WRAP_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(WRAP_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t              state_r;
    logic [WIDTH-1:0]    prev_r;
    logic [SCNT_W-1:0]   stall_cnt_r;
    logic [WRAP_W-1:0]   wrap_cnt_r;
    logic                wrap_pulse_r;
    logic                stall_r;
    logic                err_r;

    logic                is_dec_s;
    logic                is_wrap_s;
    logic                is_hold_s;
    logic [SCNT_W-1:0]   stall_inc_s;
    logic                stall_hit_s;
    logic [SCNT_W-1:0]   stall_sat_s;

    // Classify the current sample against the last accepted one.
    always_comb begin
        is_dec_s    = (count_in == expected_next(prev_r));
        is_wrap_s   = is_dec_s && is_zero(prev_r);
        is_hold_s   = (count_in == prev_r);
        stall_inc_s = stall_cnt_r + {{(SCNT_W-1){1'b0}}, 1'b1};
        stall_hit_s = (stall_inc_s == SCNT_W'(STALL_LIMIT));
        if (stall_cnt_r >= SCNT_W'(STALL_LIMIT)) begin
            stall_sat_s = SCNT_W'(STALL_LIMIT);
        end else begin
            stall_sat_s = stall_inc_s;
        end
    end

    // Monitor FSM with its statistics; clr outranks every other update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            prev_r       <= {WIDTH{1'b0}};
            stall_cnt_r  <= {SCNT_W{1'b0}};
            wrap_cnt_r   <= {WRAP_W{1'b0}};
            wrap_pulse_r <= 1'b0;
            stall_r      <= 1'b0;
            err_r        <= 1'b0;
        end else if (clr) begin
            state_r      <= ST_IDLE;
            stall_cnt_r  <= {SCNT_W{1'b0}};
            wrap_cnt_r   <= {WRAP_W{1'b0}};
            wrap_pulse_r <= 1'b0;
            stall_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            wrap_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Capture edge: the sample becomes the reference, no check.
                    if (enable) begin
                        prev_r      <= count_in;
                        stall_cnt_r <= {SCNT_W{1'b0}};
                        state_r     <= ST_TRACK;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_TRACK, ST_STALL: begin
                    if (!enable) begin
                        state_r     <= ST_IDLE;
                        stall_r     <= 1'b0;
                        stall_cnt_r <= {SCNT_W{1'b0}};
                    end else if (is_dec_s) begin
                        prev_r      <= count_in;
                        stall_cnt_r <= {SCNT_W{1'b0}};
                        stall_r     <= 1'b0;
                        state_r     <= ST_TRACK;
                        if (is_wrap_s) begin
                            wrap_pulse_r <= 1'b1;
                            wrap_cnt_r   <= wrap_inc(wrap_cnt_r);
                        end else begin
                            wrap_cnt_r   <= wrap_cnt_r;
                        end
                    end else if (is_hold_s) begin
                        if (state_r == ST_STALL) begin
                            stall_cnt_r <= stall_sat_s;
                            state_r     <= ST_STALL;
                        end else if (stall_hit_s) begin
                            stall_cnt_r <= stall_inc_s;
                            stall_r     <= 1'b1;
                            state_r     <= ST_STALL;
                        end else begin
                            stall_cnt_r <= stall_inc_s;
                            state_r     <= ST_TRACK;
                        end
                    end else begin
                        // Illegal jump: keep prev so the bad value is not trusted.
                        state_r <= ST_ERROR;
                        err_r   <= 1'b1;
                        stall_r <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    // Only clr or reset leave this state.
                    state_r <= ST_ERROR;
                    err_r   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wrap_pulse = wrap_pulse_r;
    assign wrap_cnt   = wrap_cnt_r;
    assign stall      = stall_r;
    assign err        = err_r;
    assign state      = state_r;

endmodule

// File: tb/tb_down_count_monitor.sv
// Randomized self-checking bench for down_count_monitor. Two instances run
// on the same stimulus: default parameters, and a small one (WRAP_W=2,
// STALL_LIMIT=3) that exercises wrap-counter saturation and short stalls.
`timescale 1ns/1ps

module tb_down_count_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       enable;
    logic       clr;

    logic       pulse0, stall0, err0;
    logic [7:0] wcnt0;
    logic [1:0] st0;
    logic       pulse1, stall1, err1;
    logic [1:0] wcnt1;
    logic [1:0] st1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    down_count_monitor u_dut (
        .clk(clk), .reset(reset), .count_in(count_in), .enable(enable), .clr(clr),
        .wrap_pulse(pulse0), .wrap_cnt(wcnt0), .stall(stall0), .err(err0), .state(st0)
    );

    down_count_monitor #(.WIDTH(4), .WRAP_W(2), .STALL_LIMIT(3)) u_sat (
        .clk(clk), .reset(reset), .count_in(count_in), .enable(enable), .clr(clr),
        .wrap_pulse(pulse1), .wrap_cnt(wcnt1), .stall(stall1), .err(err1), .state(st1)
    );

    // Behavioural reference: mode 0 idle, 1 tracking, 2 stalled, 3 error.
    typedef struct {
        int mode;
        int prev;
        int held;
        int wraps;
        int pulse;
        int stl;
        int er;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.mode = 0; n.prev = 0; n.held = 0; n.wraps = 0;
        n.pulse = 0; n.stl = 0; n.er = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int c, int en, int cl, int limit, int wmax);
        mdl_t n;
        n = m;
        n.pulse = 0;
        if (cl != 0) begin
            n.mode = 0; n.held = 0; n.wraps = 0; n.stl = 0; n.er = 0;
        end else if (m.mode == 3) begin
            n.er = 1;
        end else if (m.mode == 0) begin
            if (en != 0) begin
                n.prev = c; n.held = 0; n.mode = 1;
            end
        end else if (en == 0) begin
            n.mode = 0; n.stl = 0; n.held = 0;
        end else if (c == (m.prev + 15) % 16) begin
            n.prev = c; n.held = 0; n.stl = 0; n.mode = 1;
            if (m.prev == 0) begin
                n.pulse = 1;
                if (m.wraps < wmax) n.wraps = m.wraps + 1;
            end
        end else if (c == m.prev) begin
            n.held = (m.held + 1 > limit) ? limit : m.held + 1;
            if (n.held == limit) begin
                n.mode = 2; n.stl = 1;
            end
        end else begin
            n.mode = 3; n.er = 1; n.stl = 0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state",  int'(st0),    m0.mode);
        check("pulse",  int'(pulse0), m0.pulse);
        check("wcnt",   int'(wcnt0),  m0.wraps);
        check("stall",  int'(stall0), m0.stl);
        check("err",    int'(err0),   m0.er);
        check("s_state", int'(st1),    m1.mode);
        check("s_pulse", int'(pulse1), m1.pulse);
        check("s_wcnt",  int'(wcnt1),  m1.wraps);
        check("s_stall", int'(stall1), m1.stl);
        check("s_err",   int'(err1),   m1.er);
    endtask

    // Inputs are already set (at a falling edge); take one rising edge and check.
    task automatic step();
        @(posedge clk);
        m0 = mdl_step(m0, int'(count_in), int'(enable), int'(clr), 8, 255);
        m1 = mdl_step(m1, int'(count_in), int'(enable), int'(clr), 3, 3);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();
        #1;
        check_all();
        check("rst_state", int'(st0), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int cnt;
    int hold_left;
    int r;
    int r2;

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        clr      = 1'b0;
        count_in = 4'd0;
        m0 = mdl_reset();
        m1 = mdl_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Free run: capture 15, then 40 tracking edges 14,13,...
        enable   = 1'b1;
        count_in = 4'd15;
        step();
        for (int k = 1; k <= 40; k++) begin
            count_in = 4'((15 - k + 48) % 16);
            step();
            if (k == 16 || k == 32) check("wrap_edge", int'(pulse0), 1);
        end
        check("free_wcnt", int'(wcnt0), 2);
        check("free_err", int'(err0), 0);

        // Stall: hold at 5 for 8 edges, then 4.
        enable = 1'b0;
        step();
        enable   = 1'b1;
        count_in = 4'd5;
        step();
        for (int k = 0; k < 8; k++) step();
        check("stall_hi", int'(stall0), 1);
        check("stall_st", int'(st0), 2);
        count_in = 4'd4;
        step();
        check("stall_lo", int'(stall0), 0);
        check("stall_tr", int'(st0), 1);

        // Error: 9 then 3, legal counts, then clr.
        count_in = 4'd9;
        step();
        count_in = 4'd3;
        step();
        check("err_hi", int'(err0), 1);
        count_in = 4'd2;
        step();
        count_in = 4'd1;
        step();
        check("err_sticky", int'(st0), 3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_err", int'(err0), 0);
        check("clr_st", int'(st0), 0);

        // Clear coinciding with a wrap edge.
        count_in = 4'd1;
        step();
        count_in = 4'd0;
        step();
        count_in = 4'd15;
        clr      = 1'b1;
        step();
        clr = 1'b0;
        check("clr_wrap_p", int'(pulse0), 0);
        check("clr_wrap_c", int'(wcnt0), 0);

        // Randomized counter with holds, jumps, enable gaps, clears, one reset.
        cnt       = 15;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 999));
            clr = (r < 15);
            if (r >= 15 && r < 40) enable = ~enable;
            if (hold_left > 0) begin
                hold_left--;
            end else begin
                r2 = int'($urandom_range(0, 99));
                if (r2 < 8) hold_left = int'($urandom_range(1, 11));
                else if (r2 < 11) cnt = int'($urandom_range(0, 15));
                else cnt = (cnt + 15) % 16;
            end
            count_in = 4'(cnt);
            if (i == 1500) async_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/down_count_monitor.md
# down_count_monitor

Registered checker that sits directly downstream of the 4-bit down counter and consumes its `count` bus. Each cycle it verifies the counter's sequence: every step must be a decrement by 1 or a hold, with 0 wrapping to all-ones. It counts wrap-arounds, flags a stalled counter, and latches a sticky error on any illegal jump. Its outputs feed status/interrupt logic and the counter's testbench scoreboard.

## Interface
- `WIDTH`, 4: width of the monitored count bus.
- `WRAP_W`, 8: width of the wrap counter (saturating).
- `STALL_LIMIT`, 8: consecutive held samples that declare a stall. Must be ≥1.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `reset`  in  1  asynchronous, active-low reset.
- `count_in`  in  WIDTH  count from the down counter.
- `enable`  in  1  monitoring enable; low forces IDLE and keeps statistics.
- `clr`  in  1  synchronous clear of statistics and error.
- `wrap_pulse`  out  1  one-cycle pulse per legal wrap (0 → 2^WIDTH−1).
- `wrap_cnt`  out  WRAP_W  number of wraps, saturating at 2^WRAP_W−1.
- `stall`  out  1  high while in STALL.
- `err`  out  1  sticky illegal-transition flag.
- `state`  out  2  current FSM state code.

## Operation
- Internal registers:
  - `prev` (WIDTH bits): last accepted sample.
  - `stall_cnt` (clog2(STALL_LIMIT+1) bits): consecutive held samples.
- Sample classification, made against `prev`:
  - Legal decrement: `count_in == prev−1` mod 2^WIDTH.
  - Wrap: the special case `prev==0` and `count_in==` all-ones.
  - Hold: `count_in == prev`.
  - Illegal: anything else.
- States: IDLE=00, TRACK=01, STALL=10, ERROR=11.
- IDLE:
  - If `enable`=1: `prev<=count_in`, `stall_cnt<=0`, go to TRACK.
  - No check is made on the capture edge.
- TRACK:
  - Legal decrement: `prev<=count_in`, `stall_cnt<=0`. If it is a wrap, also `wrap_pulse<=1` and increment `wrap_cnt` (saturating).
  - Hold: `stall_cnt<=stall_cnt+1`. If the incremented value equals STALL_LIMIT, go to STALL and set `stall<=1`.
  - Illegal: go to ERROR and set `err<=1`. `prev` and `wrap_cnt` are unchanged.
- STALL:
  - Hold: stay. `stall_cnt` saturates at STALL_LIMIT.
  - Legal decrement: same update as in TRACK, `stall<=0`, go to TRACK.
  - Illegal: go to ERROR, `err<=1`, `stall<=0`.
- ERROR:
  - Stays until `clr` or reset. `err` stays 1.
  - `enable` has no effect in this state.
  - `wrap_pulse` and `wrap_cnt` are frozen.
- `enable`=0 in TRACK or STALL: go to IDLE. `stall<=0`, `stall_cnt<=0`. `wrap_cnt` and `err` are retained.
- `clr`=1 has highest priority, above `enable`, wrap, and error:
  - State → IDLE.
  - `wrap_cnt`, `err`, `stall`, `wrap_pulse`, `stall_cnt` all ← 0.
- `wrap_pulse` defaults to 0 on every edge unless set by a wrap on that edge.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (`reset`=0) takes effect immediately and asynchronously:
  - State=IDLE.
  - `wrap_pulse`=0, `wrap_cnt`=0, `stall`=0, `err`=0.
  - `prev`=0, `stall_cnt`=0.
  - Reset asserted mid-operation discards everything.
- Enable latency: the first classified sample is on the 2nd edge after `enable` rises (1st edge = capture).
- Wrap latency: `wrap_pulse` and the new `wrap_cnt` are visible in the cycle after the edge that samples all-ones with `prev`=0.
  - Pulse width is exactly 1 cycle.
  - Back-to-back wraps cannot occur with WIDTH≥2.
- Stall latency: `stall` rises after the STALL_LIMIT-th consecutive held sample. It falls on the edge that samples the first legal decrement.
- Error latency: `err` rises on the edge that samples the illegal value.
- Simultaneous wrap and `clr`: `clr` wins. `wrap_cnt`=0 and no pulse.

## Test plan
- Reset: run tracking, then drive `reset`=0 asynchronously between edges. All outputs go to 0 and `state`=00 immediately. After release with `enable`=1, the first edge captures.
- Free run:
  - Stimulus: `enable`=1 while a down counter presents 15, then count 15,14,…,0,15,… for 40 edges total.
  - Required: `wrap_pulse` high exactly at tracking edges 16 and 32; `wrap_cnt`=2; `err`=0, `stall`=0.
- Stall:
  - Stimulus: hold `count_in` at 5 for 8 edges, then drive 4.
  - Required: `stall`=1 and `state`=10 after the 8th hold; after the edge sampling 4, `stall`=0 and `state`=01.
- Error:
  - Stimulus: drive 9 then 3, then resume legal counts, then pulse `clr` for one cycle.
  - Required: `err`=1 and `state`=11 after the edge sampling 3; this holds through the legal counts. After `clr`: `err`=0, `wrap_cnt`=0, `state`=00.
- Saturation with WRAP_W=2: 5 wraps give `wrap_cnt`=3, and `wrap_pulse` still fires on each of the 5 wraps.
- Enable gap:
  - Stimulus: deassert `enable` at count 12 with `wrap_cnt`=1, then re-enable while `count_in`=7.
  - Required: `state`=00 during the gap; `wrap_cnt` stays 1; 7 is recaptured with no error.
  - Also: `clr` coinciding with a wrap edge gives `wrap_cnt`=0 and `wrap_pulse`=0.
